// File: rtl/cic_decimator_if.sv
// Sample/strobe bundle of the CIC decimator: the driver side supplies samples,
// strobe, sync and ratio; the filter side returns decimated samples and status.
interface cic_decimator_if #(
    parameter int CHANNELS  = 2,
    parameter int IN_WIDTH  = 2,
    parameter int OUT_WIDTH = 16,
    parameter int R_MAX     = 64
);
    localparam int RW = $clog2(R_MAX + 1);

    logic                          en_in;
    logic                          sync;
    logic [RW-1:0]                 ratio;
    logic [CHANNELS*IN_WIDTH-1:0]  in;
    logic [CHANNELS*OUT_WIDTH-1:0] out;
    logic                          out_valid;
    logic                          ratio_err;

    modport master (
        output en_in, sync, ratio, in,
        input  out, out_valid, ratio_err
    );

    modport slave (
        input  en_in, sync, ratio, in,
        output out, out_valid, ratio_err
    );
endinterface

// File: rtl/cic_decimator.sv
// Multi-channel CIC decimator: ORDER pipelined integrators per channel, one shared
// run-time-ratio phase counter, ORDER comb stages and a round/saturate output stage.
module cic_decimator #(
    parameter int CHANNELS  = 2,
    parameter int IN_WIDTH  = 2,
    parameter int ORDER     = 3,
    parameter int R_MAX     = 64,
    parameter int OUT_WIDTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    cic_decimator_if.slave bus
);
    localparam int W  = IN_WIDTH + ORDER * $clog2(R_MAX);
    localparam int RW = $clog2(R_MAX + 1);
    localparam int CW = $clog2(R_MAX);
    localparam int SH = W - OUT_WIDTH;
    localparam logic signed [W:0] RND_C = (W+1)'(1) << (SH - 1);
    localparam logic signed [W:0] MAX_C = ((W+1)'(1) << (OUT_WIDTH - 1)) - (W+1)'(1);

    typedef logic [W-1:0] acc_t;

    acc_t                          integ_q [CHANNELS][ORDER];
    acc_t                          integ_d [CHANNELS][ORDER];
    acc_t                          dly_q   [CHANNELS][ORDER];
    acc_t                          dly_d   [CHANNELS][ORDER];
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [RW-1:0]                 ratio_q, ratio_d, ratio_clamp_s;
    logic                          ratio_hit_s;
    logic                          ratio_err_q, ratio_err_d;
    logic                          dec_s;
    logic [CHANNELS*OUT_WIDTH-1:0] out_q, out_d;
    logic                          out_valid_q, out_valid_d;

    // One extra bit of headroom so the rounding add never wraps before the clip.
    function automatic logic [OUT_WIDTH-1:0] round_sat(input acc_t v);
        logic signed [W:0] ext;
        logic signed [W:0] shifted;
        ext     = $signed({v[W-1], v}) + RND_C;
        shifted = ext >>> SH;
        if (shifted > MAX_C) begin
            round_sat = MAX_C[OUT_WIDTH-1:0];
        end else begin
            round_sat = shifted[OUT_WIDTH-1:0];
        end
    endfunction

    function automatic acc_t sext_in(input logic [IN_WIDTH-1:0] s);
        sext_in = {{(W-IN_WIDTH){s[IN_WIDTH-1]}}, s};
    endfunction

    // Clamp the requested ratio into the supported 2..R_MAX range.
    always_comb begin
        if (bus.ratio < RW'(2)) begin
            ratio_clamp_s = RW'(2);
            ratio_hit_s   = 1'b1;
        end else if (bus.ratio > RW'(R_MAX)) begin
            ratio_clamp_s = RW'(R_MAX);
            ratio_hit_s   = 1'b1;
        end else begin
            ratio_clamp_s = bus.ratio;
            ratio_hit_s   = 1'b0;
        end
    end

    assign dec_s = bus.en_in && (RW'(cnt_q) == (ratio_q - RW'(1)));

    // Next-state for integrators, phase counter, ratio latch, combs and output stage.
    always_comb begin
        acc_t stage_v;
        integ_d     = integ_q;
        dly_d       = dly_q;
        cnt_d       = cnt_q;
        ratio_d     = ratio_q;
        ratio_err_d = ratio_err_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        stage_v     = '0;
        if (bus.sync) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                for (int k = 0; k < ORDER; k++) begin
                    integ_d[ch][k] = '0;
                    dly_d[ch][k]   = '0;
                end
            end
            cnt_d   = CW'(0);
            ratio_d = RW'(R_MAX);
            out_d   = '0;
        end else if (bus.en_in) begin
            // Each stage adds the registered value of the stage before it.
            for (int ch = 0; ch < CHANNELS; ch++) begin
                integ_d[ch][0] = integ_q[ch][0] + sext_in(bus.in[ch*IN_WIDTH +: IN_WIDTH]);
                for (int k = 1; k < ORDER; k++) begin
                    integ_d[ch][k] = integ_q[ch][k] + integ_q[ch][k-1];
                end
            end
            if (cnt_q == CW'(0)) begin
                ratio_d     = ratio_clamp_s;
                ratio_err_d = ratio_hit_s;
            end else begin
                ratio_d     = ratio_q;
                ratio_err_d = ratio_err_q;
            end
            if (dec_s) begin
                cnt_d       = CW'(0);
                out_valid_d = 1'b1;
                for (int ch = 0; ch < CHANNELS; ch++) begin
                    stage_v = integ_q[ch][ORDER-1];
                    for (int k = 0; k < ORDER; k++) begin
                        dly_d[ch][k] = stage_v;
                        stage_v      = stage_v - dly_q[ch][k];
                    end
                    out_d[ch*OUT_WIDTH +: OUT_WIDTH] = round_sat(stage_v);
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            integ_q     <= '{default: '0};
            dly_q       <= '{default: '0};
            cnt_q       <= CW'(0);
            ratio_q     <= RW'(R_MAX);
            ratio_err_q <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            integ_q     <= integ_d;
            dly_q       <= dly_d;
            cnt_q       <= cnt_d;
            ratio_q     <= ratio_d;
            ratio_err_q <= ratio_err_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ratio_err = ratio_err_q;

endmodule

// File: doc/cic_decimator.md
Name: cic_decimator

Overview:
Parametrised multi-channel CIC decimation filter, the generalised successor of the fixed order-3, fixed-ratio, single-channel CIC stages used in the receive chain.
- ORDER, the channel count and the output width are set at elaboration.
- The decimation ratio is set at run time.
- The block generates its own output strobe and rounds/saturates to a chosen output width.
- One instance replaces a paired I/Q filter stage in the baseband and audio decimation paths.

Parameters:
CHANNELS, 2, number of parallel channels sharing one decimation counter (e.g. I/Q)
IN_WIDTH, 2, signed input sample width per channel
ORDER, 3, number of integrator and comb stages (1..6)
R_MAX, 64, maximum decimation ratio; sets internal width W = IN_WIDTH + ORDER*$clog2(R_MAX)
OUT_WIDTH, 16, signed output width per channel (OUT_WIDTH < W)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
en_in  input  1  input sample strobe; integrators advance only when high
sync  input  1  synchronous clear of all filter state and the phase counter
ratio  input  $clog2(R_MAX+1)  requested decimation ratio, unsigned
in  input  CHANNELS*IN_WIDTH  packed signed samples; channel 0 in LSBs
out  output  CHANNELS*OUT_WIDTH  packed signed decimated samples; channel 0 in LSBs
out_valid  output  1  one-cycle pulse when out updates
ratio_err  output  1  high while the latched ratio was clamped

Behaviour:
- Reset (reset=0, asynchronous):
  - All integrators, comb delays, out, cnt and out_valid are cleared to 0.
  - ratio_q is set to R_MAX; ratio_err is cleared to 0.
  - Operation resumes on the first clk edge after deassertion.
- sync=1 at a clk edge has the same effect as reset, except ratio_err is kept. sync has priority over en_in in the same cycle.
- Ratio latch: when en_in=1 and cnt==0, ratio_q <= clamp(ratio).
  - clamp: ratio<2 -> 2; ratio>R_MAX -> R_MAX; otherwise ratio unchanged.
  - ratio_err is updated at the same edge: 1 if clamped, else 0.
  - ratio changes mid-period have no effect until the next period starts, so there are no partial periods.
- Integrators, per channel, on en_in=1: stage 1 += sign-extended in; stage k += stage k-1 (registered values).
  - Width is W; arithmetic is modulo 2^W, and wrap-around is required, not an error.
  - Every integrator adds the previous-cycle value of the stage before it, giving ORDER cycles of pipeline latency inside the integrator section.
- Phase counter cnt, on en_in=1: cnt==ratio_q-1 -> cnt <= 0 and a decimation event (dec=1) occurs; otherwise cnt <= cnt+1. cnt holds when en_in=0.
- Comb section, on dec=1 only:
  - ORDER cascaded differentiators per channel, each with one W-bit delay register, modulo 2^W.
  - Evaluated combinationally from the last integrator stage.
  - All delay registers update at the same edge.
- Output stage, at the dec edge:
  - out_ch <= sat(round(comb_ch)), where round adds 2^(W-OUT_WIDTH-1) then arithmetic-shifts right by W-OUT_WIDTH.
  - sat: values above 2^(OUT_WIDTH-1)-1 clip to that maximum. The negative side cannot overflow.
  - out_valid=1 for exactly the cycle after the dec edge, 0 otherwise.
  - out holds between events.
- Gain is ratio_q^ORDER and is not compensated; full-scale output is reached only at ratio_q=R_MAX.
- Steady state is reached after ORDER output periods. Earlier outputs are transient, but still valid-flagged.
- en_in held high continuously is legal; the output rate is then clk/ratio_q.
- All channels share cnt, dec and out_valid; channels never skew.

Test Plan:
- Reset mid-run with cnt=5 and integrators nonzero -> out=0, out_valid=0 and cnt=0 immediately (asynchronous); first out_valid comes exactly ratio en_in pulses after deassertion.
- Defaults, ratio=64, en_in always 1, in ch0=+1, ch1=-2 -> out_valid every 64 clocks; steady state ch0=16384, ch1=-32768.
- ratio=8, in ch0=+1, en_in every 3rd clock -> out_valid every 24 clocks; steady ch0=32.
- ratio=1 and ratio=100 requested -> ratio_err=1, periods of 2 and 64 en_in pulses. Then ratio=16 applied mid-period -> the current period finishes at the old ratio, the next is 16, and ratio_err=0.
- Alternating in ch0=+1/-1 for 10000 en_in pulses with ratio=64 -> integrators wrap modulo 2^20; outputs stay bounded with |out| <= 1; no saturation.
- sync pulse coincident with en_in at cnt==ratio_q-1 -> no out_valid, all state is 0, ratio_err is unchanged, and the next period starts at cnt=0.
